// File: rtl/lfsr_range_rng.sv
// Fibonacci-LFSR random number generator. It returns a value inside [MIN_VAL, MAX_VAL] by
// rejection sampling, with a bounded-retry fallback. Define LFSR_FREE_RUN_EN to let the LFSR advance every cycle.
module lfsr_range_rng #(
    parameter int unsigned      WIDTH     = 14,
    parameter logic [WIDTH-1:0] TAPS      = WIDTH'(14'h2015),
    parameter logic [WIDTH-1:0] SEED      = '1,
    parameter logic [WIDTH-1:0] MIN_VAL   = WIDTH'(1000),
    parameter logic [WIDTH-1:0] MAX_VAL   = WIDTH'(5000),
    parameter int unsigned      MAX_TRIES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req,
    input  logic             resume_n,
    input  logic             seed_we,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] random,
    output logic             rnd_ready,
    output logic             fallback
);

    localparam int unsigned     TW       = $clog2(MAX_TRIES + 1);
    localparam logic [TW-1:0]   LAST_TRY = TW'(MAX_TRIES - 1);

    typedef enum logic [1:0] {IDLE, DRAW, READY} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] lfsr, lfsr_next;
    logic [TW-1:0]    tries, tries_next;
    logic [WIDTH-1:0] random_next;
    logic             ready_next;
    logic             fallback_next;
    logic             advance;
    logic             in_range;
    logic             feedback;

    assign in_range = (lfsr >= MIN_VAL) && (lfsr <= MAX_VAL);
    assign feedback = ^(lfsr & TAPS);

    always_comb begin
        state_next    = state;
        tries_next    = tries;
        random_next   = random;
        ready_next    = rnd_ready;
        fallback_next = fallback;
`ifdef LFSR_FREE_RUN_EN
        advance       = 1'b1;
`else
        advance       = 1'b0;
`endif
        case (state)
            IDLE: begin
                tries_next    = '0;
                fallback_next = 1'b0;
                if (req) begin
                    state_next = DRAW;
                end
            end
            DRAW: begin
                if (in_range) begin
                    random_next = lfsr;
                    ready_next  = 1'b1;
                    state_next  = READY;
                end else if (tries == LAST_TRY) begin
                    random_next   = MIN_VAL;
                    fallback_next = 1'b1;
                    ready_next    = 1'b1;
                    state_next    = READY;
                end else begin
                    tries_next = tries + TW'(1);
                    advance    = 1'b1;
                end
            end
            READY: begin
                if (!resume_n) begin
                    ready_next = 1'b0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // A seed load beats both the lockup guard and advancing; a zero seed would lock the LFSR, so it maps to SEED
    always_comb begin
        lfsr_next = lfsr;
        if (seed_we) begin
            lfsr_next = (seed_in == '0) ? SEED : seed_in;
        end else if (lfsr == '0) begin
            lfsr_next = SEED;
        end else if (advance) begin
            lfsr_next = {lfsr[WIDTH-2:0], feedback};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            lfsr      <= SEED;
            tries     <= '0;
            random    <= '0;
            rnd_ready <= 1'b0;
            fallback  <= 1'b0;
        end else begin
            state     <= state_next;
            lfsr      <= lfsr_next;
            tries     <= tries_next;
            random    <= random_next;
            rnd_ready <= ready_next;
            fallback  <= fallback_next;
        end
    end

endmodule

// File: tb/tb_lfsr_range_rng.sv
// Self-checking bench for lfsr_range_rng: a default instance and a MAX_TRIES=1 instance share the
// stimulus, and both are checked every cycle against a spec-level behavioural model.
module tb_lfsr_range_rng;

    localparam int SEED_V = 16383;
    localparam int LO     = 1000;
    localparam int HI     = 5000;
    localparam int MT0    = 16;
    localparam int MT1    = 1;
    localparam int M_IDLE = 0;
    localparam int M_DRAW = 1;
    localparam int M_RDY  = 2;

    logic        clk      = 1'b0;
    logic        reset_n  = 1'b0;
    logic        req      = 1'b0;
    logic        resume_n = 1'b1;
    logic        seed_we  = 1'b0;
    logic [13:0] seed_in  = '0;
    logic [13:0] rnd0, rnd1;
    logic        rdy0, rdy1, fb0, fb1;

    int n_cmp = 0;
    int n_err = 0;
    bit check_en = 1'b0;

    typedef struct {
        int mode;
        int lfsr;
        int tries;
        int rnd;
        int rdy;
        int fb;
    } ms_t;

    ms_t m0, m1;

    lfsr_range_rng dut (
        .clk(clk), .reset_n(reset_n), .req(req), .resume_n(resume_n),
        .seed_we(seed_we), .seed_in(seed_in),
        .random(rnd0), .rnd_ready(rdy0), .fallback(fb0)
    );

    lfsr_range_rng #(.MAX_TRIES(MT1)) dut1 (
        .clk(clk), .reset_n(reset_n), .req(req), .resume_n(resume_n),
        .seed_we(seed_we), .seed_in(seed_in),
        .random(rnd1), .rnd_ready(rdy1), .fallback(fb1)
    );

    always #5 clk = ~clk;

    function automatic int lfsr_step(int x);
        return ((x << 1) & 16'h3FFF) | ($countones(x & 14'h2015) % 2);
    endfunction

    function automatic ms_t reset_state();
        ms_t s;
        s.mode = M_IDLE; s.lfsr = SEED_V; s.tries = 0; s.rnd = 0; s.rdy = 0; s.fb = 0;
        return s;
    endfunction

    // One clock of the spec's rules for an instance allowing mt rejections
    function automatic ms_t model_step(ms_t s, int mt);
        ms_t n = s;
        bit  adv = 1'b0;
`ifdef LFSR_FREE_RUN_EN
        adv = 1'b1;
`endif
        case (s.mode)
            M_IDLE: begin
                n.tries = 0;
                n.fb = 0;
                if (req) n.mode = M_DRAW;
            end
            M_DRAW: begin
                if (s.lfsr >= LO && s.lfsr <= HI) begin
                    n.rnd = s.lfsr; n.rdy = 1; n.mode = M_RDY;
                end else if (s.tries + 1 == mt) begin
                    n.rnd = LO; n.fb = 1; n.rdy = 1; n.mode = M_RDY;
                end else begin
                    n.tries = s.tries + 1;
                    adv = 1'b1;
                end
            end
            default: begin
                if (!resume_n) begin
                    n.mode = M_IDLE; n.rdy = 0;
                end
            end
        endcase
        if (seed_we) n.lfsr = (seed_in == 0) ? SEED_V : int'(seed_in);
        else if (s.lfsr == 0) n.lfsr = SEED_V;
        else if (adv) n.lfsr = lfsr_step(s.lfsr);
        return n;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m0 = reset_state();
            m1 = reset_state();
        end else begin
            m0 = model_step(m0, MT0);
            m1 = model_step(m1, MT1);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("model.random0",   32'(rnd0),      32'(m0.rnd));
            checkOutput("model.ready0",    32'(rdy0),      32'(m0.rdy));
            checkOutput("model.fallback0", 32'(fb0),       32'(m0.fb));
            checkOutput("model.lfsr0",     32'(dut.lfsr),  32'(m0.lfsr));
            checkOutput("model.random1",   32'(rnd1),      32'(m1.rnd));
            checkOutput("model.ready1",    32'(rdy1),      32'(m1.rdy));
            checkOutput("model.fallback1", 32'(fb1),       32'(m1.fb));
            checkOutput("model.lfsr1",     32'(dut1.lfsr), 32'(m1.lfsr));
        end
    end

    // Presents req (optionally with a seed load) for one cycle; returns just after the sampling edge
    task automatic applyStimulus(input bit do_seed, input logic [13:0] seed);
        @(posedge clk);
        #2;
        seed_we = do_seed;
        seed_in = seed;
        req     = 1'b1;
        @(posedge clk);
        #2;
        seed_we = 1'b0;
        req     = 1'b0;
    endtask

    // Latency counts from req being presented, so a first-candidate hit reports 2
    task automatic waitReady(input int k0, output int lat0, output int lat1);
        int  k = k0;
        bit  d0 = 1'b0;
        bit  d1 = 1'b0;
        lat0 = -1;
        lat1 = -1;
        while (k < 40 && !(d0 && d1)) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (!d0 && rdy0) begin d0 = 1'b1; lat0 = k + 1; end
            if (!d1 && rdy1) begin d1 = 1'b1; lat1 = k + 1; end
        end
        if (!(d0 && d1)) checkOutput("ready_timeout", {30'd0, d1, d0}, 32'd3);
    endtask

    task automatic resumePulse();
        @(posedge clk);
        #2;
        resume_n = 1'b0;
        @(posedge clk);
        #2;
        resume_n = 1'b1;
        @(negedge clk);
        checkOutput("resume.ready0", 32'(rdy0), 32'd0);
        checkOutput("resume.ready1", 32'(rdy1), 32'd0);
    endtask

    initial begin
        int lat0, lat1;
        bit ok;
        m0 = reset_state();
        m1 = reset_state();

        repeat (3) @(posedge clk);
        #2;
        reset_n  = 1'b1;
        check_en = 1'b1;
        @(negedge clk);
        checkOutput("reset.random",   32'(rnd0),     32'd0);
        checkOutput("reset.ready",    32'(rdy0),     32'd0);
        checkOutput("reset.fallback", 32'(fb0),      32'd0);
        checkOutput("reset.lfsr",     32'(dut.lfsr), 32'h3FFF);

        // First draw from the reset seed: 0x3FFF is rejected once, shifting in a 0
        applyStimulus(1'b0, 14'd0);
        @(posedge clk);
        @(negedge clk);
`ifndef LFSR_FREE_RUN_EN
        checkOutput("reject.lfsr", 32'(dut.lfsr), 32'h3FFE);
`endif
        waitReady(1, lat0, lat1);
        resumePulse();

        applyStimulus(1'b1, 14'd2500);
        waitReady(0, lat0, lat1);
        checkOutput("seed2500.random",  32'(rnd0), 32'd2500);
        checkOutput("seed2500.fallbk",  32'(fb0),  32'd0);
        checkOutput("seed2500.latency", 32'(lat0), 32'd2);
        checkOutput("seed2500.random1", 32'(rnd1), 32'd2500);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("hold.random", 32'(rnd0), 32'd2500);
            checkOutput("hold.ready",  32'(rdy0), 32'd1);
        end
        resumePulse();

        applyStimulus(1'b1, 14'd16383);
        waitReady(0, lat0, lat1);
        checkOutput("fallback1.random",  32'(rnd1), 32'd1000);
        checkOutput("fallback1.flag",    32'(fb1),  32'd1);
        checkOutput("fallback1.latency", 32'(lat1), 32'd2);
        resumePulse();

        // req arriving with the acknowledge, then held, restarts a draw straight from IDLE
        applyStimulus(1'b1, 14'd2500);
        waitReady(0, lat0, lat1);
        @(posedge clk);
        #2;
        req      = 1'b1;
        resume_n = 1'b0;
        @(posedge clk);
        #2;
        resume_n = 1'b1;
        @(posedge clk);
        #2;
        req = 1'b0;
        waitReady(0, lat0, lat1);
`ifndef LFSR_FREE_RUN_EN
        checkOutput("redraw.random0", 32'(rnd0), 32'd2500);
        checkOutput("redraw.random1", 32'(rnd1), 32'd2500);
`endif
        checkOutput("redraw.latency", 32'(lat0), 32'd2);

        // Asynchronous abort in the middle of a draw
        resumePulse();
        applyStimulus(1'b1, 14'd16383);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        checkOutput("abort.random0",   32'(rnd0),     32'd0);
        checkOutput("abort.ready0",    32'(rdy0),     32'd0);
        checkOutput("abort.fallback0", 32'(fb0),      32'd0);
        checkOutput("abort.random1",   32'(rnd1),     32'd0);
        checkOutput("abort.ready1",    32'(rdy1),     32'd0);
        checkOutput("abort.fallback1", 32'(fb1),      32'd0);
        checkOutput("abort.lfsr",      32'(dut.lfsr), 32'h3FFF);
        @(posedge clk);
        #2;
        reset_n = 1'b1;

        @(posedge clk);
        #2;
        seed_we = 1'b1;
        seed_in = 14'd2500;
        @(posedge clk);
        #2;
        checkOutput("seedload.lfsr", 32'(dut.lfsr), 32'd2500);
        seed_in = 14'd0;
        @(posedge clk);
        #2;
        seed_we = 1'b0;
        @(negedge clk);
        checkOutput("zeroseed.lfsr", 32'(dut.lfsr), 32'h3FFF);

        for (int d = 0; d < 1000; d++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            applyStimulus($urandom_range(0, 3) != 0, 14'($urandom_range(0, 16383)));
            waitReady(0, lat0, lat1);
            ok = ((rnd0 >= 14'd1000) && (rnd0 <= 14'd5000) && !fb0) || ((rnd0 == 14'd1000) && fb0);
            checkOutput("sweep.range0", 32'(ok), 32'd1);
            ok = ((rnd1 >= 14'd1000) && (rnd1 <= 14'd5000) && !fb1) || ((rnd1 == 14'd1000) && fb1);
            checkOutput("sweep.range1", 32'(ok), 32'd1);
            checkOutput("sweep.latency0", 32'(lat0 >= 2 && lat0 <= MT0 + 1), 32'd1);
            checkOutput("sweep.latency1", 32'(lat1 >= 2 && lat1 <= MT1 + 1), 32'd1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            resumePulse();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
